// File: rtl/updown_counter_nb.sv
// Parametrised up/down counter with programmable inclusive limits, parallel load and
// selectable terminal behaviour (wrap, saturate, reload).
module updown_counter_nb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] lim_lo,
  input  logic [WIDTH-1:0] lim_hi,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit,
  output logic             cfg_err
);

  localparam logic [1:0] ModeSat    = 2'b01;
  localparam logic [1:0] ModeReload = 2'b10;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             terminal;

  assign cfg_err  = lim_lo > lim_hi;
  assign at_limit = up ? (count_q == lim_hi) : (count_q == lim_lo);
  // Inequality rather than equality so out-of-range loaded values still terminate.
  assign terminal = up ? (count_q >= lim_hi) : (count_q <= lim_lo);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = d_in;
      reload_d = d_in;
    end else if (cfg_err) begin
      count_d = count_q;
    end else if (en) begin
      if (terminal) begin
        tc_d = 1'b1;
        case (mode)
          ModeSat:    count_d = up ? lim_hi : lim_lo;
          ModeReload: count_d = reload_q;
          default:    count_d = up ? lim_lo : lim_hi;
        endcase
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule
